// File: rtl/counter_stim_pkg.sv
// Shared types for the counter stimulus driver: command encoding, queued command
// record, FSM states and the registered pin bundle driven into the counter.
package counter_stim_pkg;

  localparam int STIM_DW         = 8;
  localparam int STIM_LEN_W      = 8;
  localparam int STIM_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    HOLD = 2'b00,
    LOAD = 2'b01,
    UP   = 2'b10,
    DOWN = 2'b11
  } stim_op_e;

  typedef struct packed {
    stim_op_e                op;
    logic [STIM_DW-1:0]      data;
    logic [STIM_LEN_W-1:0]   len;
  } stim_cmd_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fsm_e;

  typedef struct packed {
    logic               ld_n;
    logic               enb;
    logic               updn;
    logic [STIM_DW-1:0] data;
  } stim_pins_t;

  localparam stim_pins_t IDLE_PINS = '{ld_n: 1'b1, enb: 1'b0, updn: 1'b0, data: '0};

  // data_in carries the most recent LOAD value through non-LOAD commands.
  function automatic stim_pins_t op_to_pins(input stim_cmd_t cmd,
                                            input logic [STIM_DW-1:0] last_load);
    stim_pins_t p;
    p = '{ld_n: 1'b1, enb: 1'b0, updn: 1'b0, data: last_load};
    case (cmd.op)
      LOAD: begin
        p.ld_n = 1'b0;
        p.data = cmd.data;
      end
      UP: begin
        p.enb  = 1'b1;
        p.updn = 1'b1;
      end
      DOWN:    p.enb = 1'b1;
      default: ;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/counter_stim_driver_fifo.sv
// Synchronous command FIFO: single-cycle push/pop, registered occupancy,
// power-of-two depth so pointers wrap naturally.
module counter_stim_fifo
  import counter_stim_pkg::*;
#(
  parameter int DEPTH = STIM_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  stim_cmd_t                i_wr_cmd,
  output stim_cmd_t                o_rd_cmd,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  stim_cmd_t       r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;
  logic            w_push;
  logic            w_pop;

  // A full FIFO refuses the push even when a pop frees a slot in the same cycle.
  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage is not reset; occupancy and pointers alone define validity,
  // so the array can map onto plain RAM/flops without reset muxes.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wr_cmd;
  end

  assign o_rd_cmd = r_mem[r_rd_ptr];
  assign o_full   = (r_count == (AW+1)'(DEPTH));
  assign o_empty  = (r_count == '0);
  assign o_count  = r_count;

endmodule

// File: rtl/counter_stim_driver.sv
// Command-driven stimulus generator for the 8-bit up/down loadable counter,
// with a shadow model of the counter value for scoreboard comparison.
module counter_stim_driver
  import counter_stim_pkg::*;
#(
  parameter int DW         = STIM_DW,
  parameter int LEN_W      = STIM_LEN_W,
  parameter int FIFO_DEPTH = STIM_FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [DW-1:0]    cmd_data,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             ld_cnt_,
  output logic             updn_cnt,
  output logic             count_enb,
  output logic [DW-1:0]    data_in,
  output logic [DW-1:0]    exp_data,
  output logic             busy,
  output logic             done
);

  fsm_e                        r_state;
  fsm_e                        w_state_nxt;
  logic [LEN_W-1:0]            r_rem;
  logic [LEN_W-1:0]            w_rem_nxt;
  stim_pins_t                  r_pins;
  stim_pins_t                  w_pins_nxt;
  logic [DW-1:0]               r_last_load;
  logic [DW-1:0]               w_last_load_nxt;
  logic [DW-1:0]               r_exp;

  stim_cmd_t                   w_wr_cmd;
  stim_cmd_t                   w_head;
  logic                        w_full;
  logic                        w_empty;
  logic [$clog2(FIFO_DEPTH):0] w_count;
  logic                        w_last;
  logic                        w_pop;

  assign w_wr_cmd = '{op: stim_op_e'(cmd_op), data: cmd_data, len: cmd_len};

  counter_stim_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .i_push   (cmd_valid),
    .i_pop    (w_pop),
    .i_wr_cmd (w_wr_cmd),
    .o_rd_cmd (w_head),
    .o_full   (w_full),
    .o_empty  (w_empty),
    .o_count  (w_count)
  );

  // Pop on the idle edge or on the edge that ends the last drive cycle, so
  // consecutive commands run with no bubble.
  assign w_last = (r_state == RUN) && (r_rem == '0);
  assign w_pop  = !w_empty && ((r_state == IDLE) || w_last);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case leaves it unassigned and infers a latch.
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (!w_empty) w_state_nxt = RUN;
      RUN:     if (w_last && w_empty) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_pins_nxt      = r_pins;
    w_rem_nxt       = r_rem;
    w_last_load_nxt = r_last_load;
    if (w_pop) begin
      w_pins_nxt = op_to_pins(w_head, r_last_load);
      w_rem_nxt  = w_head.len;
      if (w_head.op == LOAD) w_last_load_nxt = w_head.data;
    end else if (w_state_nxt == IDLE) begin
      w_pins_nxt = IDLE_PINS;
    end else if (!w_last) begin
      w_rem_nxt = r_rem - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pins      <= IDLE_PINS;
      r_rem       <= '0;
      r_last_load <= '0;
    end else begin
      r_pins      <= w_pins_nxt;
      r_rem       <= w_rem_nxt;
      r_last_load <= w_last_load_nxt;
    end
  end

  // Shadow counter tracks what the counter will do with the pins driven now;
  // load wins over count, arithmetic wraps mod 2^DW.
  always_ff @(posedge clk) begin
    if (rst)               r_exp <= '0;
    else if (!r_pins.ld_n) r_exp <= r_pins.data;
    else if (r_pins.enb)   r_exp <= r_pins.updn ? r_exp + 1'b1 : r_exp - 1'b1;
  end

  assign ld_cnt_   = r_pins.ld_n;
  assign count_enb = r_pins.enb;
  assign updn_cnt  = r_pins.updn;
  assign data_in   = r_pins.data;
  assign exp_data  = r_exp;
  assign cmd_ready = !w_full;
  assign done      = w_last;
  assign busy      = (r_state == RUN) || (w_count != '0);

endmodule
